// File: rtl/sha256_core_arbiter_pkg.sv
// Shared types and widths for the SHA-256 core arbiter slice.
package sha256_pkg;

    localparam int SHA256_BLOCK_W  = 512;
    localparam int SHA256_DIGEST_W = 256;

    // Arbiter FSM: wait for a request, feed a block, wait for its digest, hold the final digest.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/sha256_core_arbiter_if.sv
// Bundle of requester, core and digest handshakes around the SHA-256 core arbiter.
// The master modport is the arbiter's view; slave is the surrounding logic.
interface sha256_core_arbiter_if #(
    parameter int num_req_p       = 2,
    parameter int blk_cnt_width_p = 16
);
    import sha256_pkg::*;

    localparam int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    logic [num_req_p-1:0]                req_v_i;
    logic [num_req_p*SHA256_BLOCK_W-1:0] req_data_i;
    logic [num_req_p-1:0]                req_last_i;
    logic [num_req_p-1:0]                req_ready_o;

    logic                                core_v_o;
    logic                                core_init_o;
    logic [SHA256_BLOCK_W-1:0]           core_msg_o;
    logic                                core_ready_i;
    logic                                core_v_i;
    logic [SHA256_DIGEST_W-1:0]          core_digest_i;
    logic                                core_yumi_o;

    logic                                digest_v_o;
    logic [SHA256_DIGEST_W-1:0]          digest_o;
    logic [lg_num_req_lp-1:0]            digest_id_o;
    logic [blk_cnt_width_p-1:0]          digest_blocks_o;
    logic                                digest_yumi_i;
    logic                                busy_o;

    modport master (
        input  req_v_i, req_data_i, req_last_i, core_ready_i, core_v_i,
               core_digest_i, digest_yumi_i,
        output req_ready_o, core_v_o, core_init_o, core_msg_o, core_yumi_o,
               digest_v_o, digest_o, digest_id_o, digest_blocks_o, busy_o
    );

    modport slave (
        output req_v_i, req_data_i, req_last_i, core_ready_i, core_v_i,
               core_digest_i, digest_yumi_i,
        input  req_ready_o, core_v_o, core_init_o, core_msg_o, core_yumi_o,
               digest_v_o, digest_o, digest_id_o, digest_blocks_o, busy_o
    );

endinterface

// File: rtl/sha256_core_arbiter_chk.sv
// Protocol checks for the SHA-256 core arbiter: stray core digests and picker sanity.
module sha256_core_arbiter_chk
    import sha256_pkg::*;
#(
    parameter int num_req_p = 2
) (
    input logic                 clk_i,
    input logic                 reset_i,
    input state_e               state,
    input logic                 core_v,
    input logic [num_req_p-1:0] gnt,
    input logic                 any
);

    // The core must only present a digest while the arbiter is waiting for one.
    a_core_v_in_wait: assert property (@(posedge clk_i) disable iff (!reset_i)
        core_v |-> (state == WAIT))
        else $error("core digest valid while arbiter not waiting");

    // The picker grants at most one requester, and only when one is requesting.
    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!reset_i)
        $onehot0(gnt) && (any == (gnt != '0)))
        else $error("round-robin grant not one-hot or inconsistent with any");

endmodule

// File: rtl/sha256_core_arbiter_rr_arb.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module sha256_rr_arb #(
    parameter int num_req_p     = 2,
    parameter int lg_num_req_lp = 1
) (
    input  logic [num_req_p-1:0]     req,
    input  logic [lg_num_req_lp-1:0] ptr,
    output logic [num_req_p-1:0]     gnt,
    output logic [lg_num_req_lp-1:0] id,
    output logic                     any
);

    // Scan requesters starting at ptr; the first one found wins.
    always_comb begin : pick
        logic [lg_num_req_lp-1:0] idx;
        idx = '0;
        gnt = '0;
        id  = '0;
        any = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            idx = lg_num_req_lp'((int'(ptr) + i) % num_req_p);
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                id       = idx;
                any      = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/sha256_core_arbiter.sv
// Shares one SHA-256 core between num_req_p requesters. A granted requester
// owns the core for a whole message; ownership rotates round-robin per message.
module sha256_core_arbiter
    import sha256_pkg::*;
#(
    parameter int num_req_p       = 2,
    parameter int blk_cnt_width_p = 16
) (
    input logic                   clk_i,
    input logic                   reset_i,
    sha256_core_arbiter_if.master bus
);

    localparam int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam logic [lg_num_req_lp-1:0] last_id_lp = lg_num_req_lp'(num_req_p - 1);

    state_e                     state_r;
    state_e                     state_s;
    logic [lg_num_req_lp-1:0]   owner_r;
    logic [lg_num_req_lp-1:0]   rr_ptr_r;
    logic                       first_r;
    logic                       last_r;
    logic [blk_cnt_width_p-1:0] blk_cnt_r;
    logic [SHA256_DIGEST_W-1:0] digest_r;
    logic [lg_num_req_lp-1:0]   digest_id_r;
    logic [blk_cnt_width_p-1:0] digest_blocks_r;

    logic [num_req_p-1:0]       arb_gnt_s;
    logic [lg_num_req_lp-1:0]   arb_id_s;
    logic                       arb_any_s;

    logic                       owner_v_s;
    logic [SHA256_BLOCK_W-1:0]  owner_msg_s;
    logic                       grant_s;
    logic                       xfer_s;
    logic                       final_s;
    logic                       release_s;

    sha256_rr_arb #(
        .num_req_p     (num_req_p),
        .lg_num_req_lp (lg_num_req_lp)
    ) u_rr_arb (
        .req (bus.req_v_i),
        .ptr (rr_ptr_r),
        .gnt (arb_gnt_s),
        .id  (arb_id_s),
        .any (arb_any_s)
    );

    sha256_core_arbiter_chk #(
        .num_req_p (num_req_p)
    ) u_chk (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .state   (state_r),
        .core_v  (bus.core_v_i),
        .gnt     (arb_gnt_s),
        .any     (arb_any_s)
    );

    assign owner_v_s   = bus.req_v_i[owner_r];
    assign owner_msg_s = bus.req_data_i[int'(owner_r)*SHA256_BLOCK_W +: SHA256_BLOCK_W];

    // Next-state and handshake decode; every output idles at zero unless its state drives it.
    always_comb begin
        state_s         = state_r;
        grant_s         = 1'b0;
        xfer_s          = 1'b0;
        final_s         = 1'b0;
        release_s       = 1'b0;
        bus.req_ready_o = '0;
        bus.core_v_o    = 1'b0;
        bus.core_init_o = 1'b0;
        bus.core_msg_o  = '0;
        bus.core_yumi_o = 1'b0;
        case (state_r)
            IDLE: begin
                if (arb_any_s) begin
                    grant_s = 1'b1;
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                bus.core_v_o             = owner_v_s;
                bus.core_msg_o           = owner_msg_s;
                bus.core_init_o          = first_r & owner_v_s;
                bus.req_ready_o[owner_r] = bus.core_ready_i;
                if (owner_v_s && bus.core_ready_i) begin
                    xfer_s  = 1'b1;
                    state_s = WAIT;
                end else begin
                    state_s = ISSUE;
                end
            end
            WAIT: begin
                if (bus.core_v_i) begin
                    bus.core_yumi_o = 1'b1;
                    if (last_r) begin
                        final_s = 1'b1;
                        state_s = DONE;
                    end else begin
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            DONE: begin
                if (bus.digest_yumi_i) begin
                    release_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Message ownership, first/last block tracking, block count and rotation pointer.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            owner_r   <= '0;
            rr_ptr_r  <= '0;
            first_r   <= 1'b1;
            last_r    <= 1'b0;
            blk_cnt_r <= '0;
        end else if (grant_s) begin
            owner_r   <= arb_id_s;
            first_r   <= 1'b1;
            blk_cnt_r <= '0;
        end else if (xfer_s) begin
            last_r  <= bus.req_last_i[owner_r];
            first_r <= 1'b0;
            if (blk_cnt_r != '1) begin
                blk_cnt_r <= blk_cnt_r + blk_cnt_width_p'(1);
            end
        end else if (release_s) begin
            rr_ptr_r <= (owner_r == last_id_lp) ? '0 : owner_r + lg_num_req_lp'(1);
        end
    end

    // Final digest holding register, loaded only from the last block's digest.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            digest_r        <= '0;
            digest_id_r     <= '0;
            digest_blocks_r <= '0;
        end else if (final_s) begin
            digest_r        <= bus.core_digest_i;
            digest_id_r     <= owner_r;
            digest_blocks_r <= blk_cnt_r;
        end
    end

    assign bus.digest_v_o      = (state_r == DONE);
    assign bus.digest_o        = digest_r;
    assign bus.digest_id_o     = digest_id_r;
    assign bus.digest_blocks_o = digest_blocks_r;
    assign bus.busy_o          = (state_r != IDLE);

endmodule
